// File: rtl/spm_pipe.sv
// Single-port scratchpad with valid/ready request/response, byte enables, range error and post-reset zeroisation.
// Response visible RD_LAT edges after accept; a credit limit keeps responses inside the RD_LAT+1 entry queue under backpressure.
module spm_pipe #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int BE_W = DATA_W / 8;
  localparam int FD   = RD_LAT + 1;
  localparam int CW   = $clog2(FD + 1);
  localparam int IW   = $clog2(FD);
  localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [MW-1:0]     LAST_L  = MW'(DEPTH - 1);
  localparam logic [CW-1:0]     FD_L    = CW'(FD);

  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] dat;
  } rsp_t;

  state_t            state_q, state_d;
  logic [MW-1:0]     clr_q, clr_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  rsp_t              fifo_q [FD];
  rsp_t              fifo_d [FD];
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_range, hs, acc;
  rsp_t              acc_rsp;
  logic              push_vld;
  rsp_t              push_rsp;
  logic              wr_en;
  logic [MW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_dat;
  logic [BE_W-1:0]   wr_be;
  logic [IW-1:0]     wr_idx;

  assign in_range  = {1'b0, req_addr} < DEPTH_L;
  assign rsp_valid = cnt_q != '0;
  assign rsp_rdata = rsp_valid ? fifo_q[0].dat : '0;
  assign rsp_err   = rsp_valid && fifo_q[0].err;
  assign busy      = state_q == INIT;
  assign hs        = rsp_valid && rsp_ready;
  // A hand-off in the same cycle frees a credit, so a full queue still streams.
  assign req_ready = rst && (state_q == RUN) && ((inflight_q < FD_L) || hs);
  assign acc       = req_valid && req_ready;

  always_comb begin
    acc_rsp.err = !in_range;
    acc_rsp.dat = (!req_write && in_range) ? mem_q[req_addr[MW-1:0]] : '0;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = req_addr[MW-1:0];
    wr_dat  = req_wdata;
    wr_be   = req_be;
    if (state_q == INIT) begin
      wr_en   = 1'b1;
      wr_addr = clr_q;
      wr_dat  = '0;
      wr_be   = '1;
    end else if (acc && req_write && in_range) begin
      wr_en = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    inflight_d = inflight_q + CW'(acc) - CW'(hs);
    if (state_q == INIT) begin
      clr_d = clr_q + MW'(1);
      if (clr_q == LAST_L) state_d = RUN;
    end
  end

  // The accept edge is the first latency stage; RD_LAT-1 more registers follow.
  if (RD_LAT == 1) begin : g_nopipe
    assign push_vld = acc;
    assign push_rsp = acc_rsp;
  end else begin : g_pipe
    logic pv_q [RD_LAT-1];
    logic pv_d [RD_LAT-1];
    rsp_t pr_q [RD_LAT-1];
    rsp_t pr_d [RD_LAT-1];

    always_comb begin
      pv_d[0] = acc;
      pr_d[0] = acc_rsp;
      for (int i = 1; i < RD_LAT - 1; i++) begin
        pv_d[i] = pv_q[i-1];
        pr_d[i] = pr_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pv_q <= '{default: 1'b0};
        pr_q <= '{default: '0};
      end else begin
        pv_q <= pv_d;
        pr_q <= pr_d;
      end
    end

    assign push_vld = pv_q[RD_LAT-2];
    assign push_rsp = pr_q[RD_LAT-2];
  end

  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (hs) begin
      for (int i = 0; i < FD - 1; i++) fifo_d[i] = fifo_q[i+1];
      cnt_d = cnt_q - CW'(1);
    end
    wr_idx = IW'(cnt_d);
    if (push_vld) begin
      fifo_d[wr_idx] = push_rsp;
      cnt_d          = cnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
      clr_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      fifo_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem_q[wr_addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_spm_pipe.sv
// Scenario bench for spm_pipe (32-bit, depth 200, read latency 2, zeroised after reset)
// against a word-array and response-queue reference model.
module tb_spm_pipe;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int DEP = 200;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;

  spm_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mdl [DEP];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          acc_cyc_q[$];
  int          got_cyc_q[$];

  logic        s_busy, s_rdy, s_vld, last_acc;
  logic [31:0] s_dat;

  // One clock: sample at the falling edge, update the model for any accept, return just after the rising edge.
  task automatic cycle();
    logic [32:0] e;
    @(negedge clk);
    s_busy   = busy;
    s_rdy    = req_ready;
    s_vld    = rsp_valid;
    s_dat    = rsp_rdata;
    last_acc = req_valid && req_ready;
    if (rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_err, rsp_rdata});
      got_cyc_q.push_back(cyc);
    end
    if (last_acc) begin
      if (int'(req_addr) >= DEP) e = {1'b1, 32'h0};
      else if (req_write) begin
        for (int b = 0; b < 4; b++)
          if (req_be[b]) mdl[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        e = 33'h0;
      end else e = {1'b0, mdl[req_addr]};
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout addr=%0d: no accept seen, required an accept", a);
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (got_q.size() >= exp_q.size()) break;
      cycle();
    end
    repeat (LAT + 2) cycle();
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEP; i++) mdl[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n_busy, bad_rdy;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    zero_model();
    #23;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b want=1", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b1;
    n_busy = 0; bad_rdy = 0;
    for (int k = 0; k < 1000; k++) begin
      cycle();
      if (!s_busy) break;
      n_busy++;
      if (s_rdy) bad_rdy++;
    end
    req_valid = 1'b0;
    checks++; if (n_busy != DEP) begin errors++; $display("FAIL init_busy_cycles got=%0d want=%0d", n_busy, DEP); end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL init_ready_low got=%0d ready cycles want=0", bad_rdy); end
  endtask

  task automatic test_clear();
    int nz;
    for (int a = 0; a < DEP; a++) issue(1'b0, 8'(a), 32'h0, 4'h0);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL clear_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    nz = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e || g !== 33'h0) begin
        errors++; nz++;
        if (nz < 5) $display("FAIL clear_read got=%h want=%h", g, e);
      end
    end
  endtask

  task automatic test_byte_en();
    logic [32:0] r [8];
    int n;
    issue(1'b1, 8'd3, 32'hDEADBEEF, 4'b1111);
    issue(1'b1, 8'd3, 32'h11223344, 4'b0101);
    issue(1'b0, 8'd3, 32'h0, 4'h0);
    issue(1'b1, 8'd3, 32'hFFFFFFFF, 4'b0000);
    issue(1'b0, 8'd3, 32'h0, 4'h0);
    drain();
    checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      errors++; $display("FAIL be_count got=%0d want=5", got_q.size());
    end
    n = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (n < 8) r[n] = g;
      n++;
      checks++;
      if (g !== e) begin errors++; $display("FAIL be_rsp%0d got=%h want=%h", n - 1, g, e); end
    end
    if (n >= 5) begin
      checks++; if (r[2] !== {1'b0, 32'hDE22BE44}) begin errors++; $display("FAIL be_merge got=%h want=0de22be44", r[2]); end
      checks++; if (r[4] !== {1'b0, 32'hDE22BE44}) begin errors++; $display("FAIL be_zero_mask got=%h want=0de22be44", r[4]); end
      checks++; if (r[0] !== 33'h0) begin errors++; $display("FAIL be_write_rsp got=%h want=0", r[0]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [32:0] r [8];
    int n;
    issue(1'b1, 8'd199, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 8'd250, 32'h00000055, 4'hF);
    issue(1'b0, 8'd250, 32'h0, 4'h0);
    issue(1'b0, 8'd199, 32'h0, 4'h0);
    drain();
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++; $display("FAIL oor_count got=%0d want=4", got_q.size());
    end
    n = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (n < 8) r[n] = g;
      n++;
      checks++;
      if (g !== e) begin errors++; $display("FAIL oor_rsp%0d got=%h want=%h", n - 1, g, e); end
    end
    if (n >= 4) begin
      checks++; if (r[1] !== {1'b1, 32'h0}) begin errors++; $display("FAIL oor_write got=%h want=100000000", r[1]); end
      checks++; if (r[2] !== {1'b1, 32'h0}) begin errors++; $display("FAIL oor_read got=%h want=100000000", r[2]); end
      checks++; if (r[3] !== {1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL oor_neighbour got=%h want=0cafef00d", r[3]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] wd [4];
    logic [31:0] held;
    logic        held_seen;
    int          i, unstable, n;
    for (int k = 0; k < 4; k++) begin
      wd[k] = $urandom();
      issue(1'b1, 8'(10 + k), wd[k], 4'hF);
    end
    drain();
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL bp_setup got=%h want=%h", g, e); end
    end
    rsp_ready = 1'b0;
    i = 0; unstable = 0; held = '0; held_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(10 + i);
      cycle();
      if (last_acc) i++;
      if (s_vld) begin
        if (!held_seen) begin held = s_dat; held_seen = 1'b1; end
        else if (s_dat !== held) unstable++;
      end
    end
    checks++; if (i != 3) begin errors++; $display("FAIL bp_accepted got=%0d want=3", i); end
    checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b want=0", s_rdy); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_handoff got=%0d want=0", got_q.size()); end
    checks++; if (!held_seen || held !== wd[0] || unstable != 0) begin
      errors++; $display("FAIL bp_hold got=%h unstable=%0d want=%h unstable=0", held, unstable, wd[0]);
    end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && i < 4; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'(10 + i);
      cycle();
      if (last_acc) i++;
    end
    checks++; if (i != 4) begin errors++; $display("FAIL bp_fourth got=%0d accepted want=4", i); end
    drain();
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++; $display("FAIL bp_count got=%0d want=4", got_q.size());
    end
    n = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e || (n < 4 && g !== {1'b0, wd[n]})) begin
        errors++; $display("FAIL bp_order%0d got=%h want=%h", n, g, e);
      end
      n++;
    end
  endtask

  task automatic test_stream();
    int n, used, nbad, lbad;
    acc_cyc_q.delete();
    got_cyc_q.delete();
    rsp_ready = 1'b1;
    n = 0; used = 0;
    while (n < 100 && used < 300) begin
      req_valid = 1'b1;
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 220));
      req_wdata = $urandom();
      req_be    = 4'($urandom_range(0, 15));
      cycle();
      used++;
      if (last_acc) n++;
    end
    checks++; if (used != 100) begin errors++; $display("FAIL stream_throughput got=%0d cycles want=100", used); end
    drain();
    checks++;
    if (got_q.size() != 100 || exp_q.size() != 100) begin
      errors++; $display("FAIL stream_count got=%0d want=100", got_q.size());
    end
    nbad = 0; lbad = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      int ga, gc;
      g = got_q.pop_front(); e = exp_q.pop_front();
      ga = acc_cyc_q.pop_front(); gc = got_cyc_q.pop_front();
      checks++;
      if (g !== e) begin
        nbad++;
        errors++;
        if (nbad < 5) $display("FAIL stream_data got=%h want=%h", g, e);
      end
      checks++;
      if (gc - ga != LAT) begin
        lbad++;
        errors++;
        if (lbad < 5) $display("FAIL stream_latency got=%0d want=%0d", gc - ga, LAT);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_busy, stale;
    rsp_ready = 1'b0;
    issue(1'b0, 8'd10, 32'h0, 4'h0);
    issue(1'b0, 8'd11, 32'h0, 4'h0);
    req_valid = 1'b0;
    cycle();
    cycle();
    checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL mid_queued got=%b want=1", s_vld); end
    rst = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_busy_ready got=%b/%b want=1/0", busy, req_ready);
    end
    exp_q.delete(); got_q.delete();
    zero_model();
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_ready = 1'b1;
    n_busy = 0; stale = 0;
    for (int k = 0; k < 1000; k++) begin
      cycle();
      if (s_vld) stale++;
      if (!s_busy) break;
      n_busy++;
    end
    checks++; if (n_busy != DEP) begin errors++; $display("FAIL mid_init_cycles got=%0d want=%0d", n_busy, DEP); end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale got=%0d want=0", stale); end
    issue(1'b0, 8'd10, 32'h0, 4'h0);
    drain();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL mid_count got=%0d want=1", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [32:0] g, e;
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e || g !== 33'h0) begin errors++; $display("FAIL mid_cleared got=%h want=%h", g, e); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_byte_en();
    test_out_of_range();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
